// File: rtl/pow_pipe_pkg.sv
// Shared types and the single multiply step of the power pipeline.
// The step works on a fixed maximum width; callers zero-extend and take the low W bits.
package pow_pipe_pkg;

  localparam int POW_MODE_WRAP = 0;
  localparam int POW_MODE_SAT  = 1;
  localparam int POW_MAX_W     = 32;

  typedef logic [POW_MAX_W-1:0] pow_word_t;
  typedef logic [POW_MAX_W:0]   pow_step_t;

  // Returns {ovf_out, p}; p is confined to the low w bits, saturating to all-ones when asked.
  function automatic pow_step_t pow_mul_step(input pow_word_t   a,
                                             input pow_word_t   n,
                                             input logic        ovf_in,
                                             input logic        sat,
                                             input int unsigned w);
    logic [2*POW_MAX_W-1:0] prod;
    pow_word_t              mask;
    pow_word_t              p;
    logic                   ovf_out;
    prod    = {{POW_MAX_W{1'b0}}, a} * {{POW_MAX_W{1'b0}}, n};
    mask    = (w >= POW_MAX_W) ? '1 : pow_word_t'((64'd1 << w) - 64'd1);
    ovf_out = ovf_in | ((prod >> w) != '0);
    p       = prod[POW_MAX_W-1:0] & mask;
    if (sat && ovf_out) p = mask;
    return {ovf_out, p};
  endfunction

endpackage

// File: rtl/pow_pipe_stage.sv
// One pipeline stage: computes power STAGE+1 from the previous partial power and n.
// Loads when i_adv (empty or downstream moving), otherwise holds valid and data.
module pow_pipe_stage
  import pow_pipe_pkg::*;
#(
  parameter int W        = 8,
  parameter int N_STAGES = 4,
  parameter int STAGE    = 1,
  parameter int SAT      = POW_MODE_WRAP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_vld,
  input  logic                  i_adv,
  input  logic [W-1:0]          i_n,
  input  logic [W*N_STAGES-1:0] i_pw,
  input  logic [N_STAGES-1:0]   i_ovf,
  output logic                  o_vld,
  output logic [W-1:0]          o_n,
  output logic [W*N_STAGES-1:0] o_pw,
  output logic [N_STAGES-1:0]   o_ovf
);

  localparam int SLOT = STAGE - 1;

  logic                  r_vld;
  logic [W-1:0]          r_n;
  logic [W*N_STAGES-1:0] r_pw;
  logic [N_STAGES-1:0]   r_ovf;

  logic [W-1:0]          w_a;
  logic                  w_ovf_in;
  pow_step_t             w_step;
  logic                  w_unused_step;
  logic [W*N_STAGES-1:0] w_pw_nxt;
  logic [N_STAGES-1:0]   w_ovf_nxt;

  // The first stage squares n; later stages extend the previous power.
  generate
    if (STAGE == 1) begin : g_first
      assign w_a      = i_n;
      assign w_ovf_in = 1'b0;
    end else begin : g_next
      assign w_a      = i_pw[(SLOT-1)*W +: W];
      assign w_ovf_in = i_ovf[SLOT-1];
    end
  endgenerate

  assign w_step        = pow_mul_step(pow_word_t'(w_a), pow_word_t'(i_n), w_ovf_in,
                                      SAT == POW_MODE_SAT, W);
  assign w_unused_step = ^w_step;

  always_comb begin
    w_pw_nxt                 = i_pw;
    w_pw_nxt[SLOT*W +: W]    = w_step[W-1:0];
    w_ovf_nxt                = i_ovf;
    w_ovf_nxt[SLOT]          = w_step[POW_MAX_W];
  end

  always_ff @(posedge clk) begin
    if (rst) r_vld <= 1'b0;
    else if (i_adv) r_vld <= i_vld;
  end

  always_ff @(posedge clk) begin
    if (i_adv && i_vld) begin
      r_n   <= i_n;
      r_pw  <= w_pw_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  assign o_vld = r_vld;
  assign o_n   = r_n;
  assign o_pw  = r_pw;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/pow_n_pipe_bp.sv
// Pipelined n^2..n^(N_STAGES+1) with sticky overflow; N_STAGES+1 cycles latency, 1/cycle.
// Valid/ready backpressure with bubble collapsing; in_rdy is combinational from out_rdy.
module pow_n_pipe_bp
  import pow_pipe_pkg::*;
#(
  parameter int W        = 8,
  parameter int N_STAGES = 4,
  parameter int SAT      = POW_MODE_WRAP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [W-1:0]          n,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [W*N_STAGES-1:0] res,
  output logic [N_STAGES-1:0]   ovf
);

  logic                  r_vld0;
  logic [W-1:0]          r_n0;

  logic [N_STAGES:0]     w_vld;
  logic [N_STAGES+1:0]   w_rdy;
  logic [W-1:0]          w_n   [0:N_STAGES];
  logic [W*N_STAGES-1:0] w_pw  [0:N_STAGES];
  logic [N_STAGES-1:0]   w_ovf [0:N_STAGES];
  logic                  w_unused_n;

  // Whole ready chain in one block: each stage accepts if empty or its successor accepts.
  always_comb begin
    w_rdy[N_STAGES+1] = out_rdy;
    for (int j = N_STAGES; j >= 0; j--) begin
      w_rdy[j] = !w_vld[j] || w_rdy[j+1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_vld0 <= 1'b0;
    else if (w_rdy[0]) r_vld0 <= in_vld;
  end

  always_ff @(posedge clk) begin
    if (w_rdy[0] && in_vld) r_n0 <= n;
  end

  assign w_vld[0] = r_vld0;
  assign w_n[0]   = r_n0;
  assign w_pw[0]  = '0;
  assign w_ovf[0] = '0;

  generate
    for (genvar j = 1; j <= N_STAGES; j++) begin : g_stage
      pow_pipe_stage #(
        .W        (W),
        .N_STAGES (N_STAGES),
        .STAGE    (j),
        .SAT      (SAT)
      ) u_stage (
        .clk   (clk),
        .rst   (rst),
        .i_vld (w_vld[j-1]),
        .i_adv (w_rdy[j]),
        .i_n   (w_n[j-1]),
        .i_pw  (w_pw[j-1]),
        .i_ovf (w_ovf[j-1]),
        .o_vld (w_vld[j]),
        .o_n   (w_n[j]),
        .o_pw  (w_pw[j]),
        .o_ovf (w_ovf[j])
      );
    end
  endgenerate

  assign w_unused_n = ^w_n[N_STAGES];

  assign in_rdy  = w_rdy[0];
  assign out_vld = w_vld[N_STAGES];
  assign res     = w_pw[N_STAGES];
  assign ovf     = w_ovf[N_STAGES];

endmodule

// File: tb/tb_pow_n_pipe_bp.sv
// Directed bench for pow_n_pipe_bp (W=8, N_STAGES=4), wrap and saturate instances in lockstep.
// A negedge monitor scores every visible output against a reference queue.
module tb_pow_n_pipe_bp;

  logic        clk = 1'b0;
  logic        rst, in_vld, out_rdy;
  logic [7:0]  n;
  logic        in_rdy, in_rdy_s, out_vld, out_vld_s;
  logic [31:0] res, res_s;
  logic [3:0]  ovf, ovf_s;

  int   n_checks = 0;
  int   n_err    = 0;
  bit   mon_en   = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  pow_n_pipe_bp #(.W(8), .N_STAGES(4), .SAT(0)) u_dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .n(n),
    .out_vld(out_vld), .out_rdy(out_rdy), .res(res), .ovf(ovf));

  pow_n_pipe_bp #(.W(8), .N_STAGES(4), .SAT(1)) u_dut_sat (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy_s), .n(n),
    .out_vld(out_vld_s), .out_rdy(out_rdy), .res(res_s), .ovf(ovf_s));

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Returns {ovf[3:0], res[31:0]} for operand x.
  function automatic logic [35:0] model(input logic [7:0] x, input bit sat);
    logic [15:0] prod;
    logic [7:0]  p;
    logic        o;
    logic [35:0] r;
    p = x;
    o = 1'b0;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      prod = {8'd0, p} * {8'd0, x};
      o    = o | (prod[15:8] != 8'd0);
      p    = (sat && o) ? 8'hFF : prod[7:0];
      r[k*8 +: 8] = p;
      r[32 + k]   = o;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() == 0) begin
          check("stray_out", {63'd0, out_vld}, 64'd0);
        end else if (out_vld) begin
          check("mon_res",   {32'd0, res},   {32'd0, model(exp_q[0], 0)[31:0]});
          check("mon_ovf",   {60'd0, ovf},   {60'd0, model(exp_q[0], 0)[35:32]});
          check("mon_res_s", {32'd0, res_s}, {32'd0, model(exp_q[0], 1)[31:0]});
          check("mon_ovf_s", {60'd0, ovf_s}, {60'd0, model(exp_q[0], 1)[35:32]});
          if (out_rdy) void'(exp_q.pop_front());
        end
        if (in_vld && in_rdy) exp_q.push_back(n);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_rdy = 1'b1;
    in_vld  = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    repeat (2) tick();
    check("drained", exp_q.size(), 64'd0);
  endtask

  // Single operand into an empty pipe; measures latency and compares hand-computed results.
  task automatic run_one(input string tag, input logic [7:0] x, input logic [31:0] e_res,
                         input logic [31:0] e_res_s, input logic [3:0] e_ovf);
    int edges;
    out_rdy = 1'b1;
    in_vld  = 1'b1;
    n       = x;
    @(posedge clk);
    edges = 1;
    #1 in_vld = 1'b0;
    while (edges < 20) begin
      @(negedge clk);
      if (out_vld) break;
      tick();
      edges++;
    end
    check({tag, "_lat"}, edges, 64'd5);
    check({tag, "_vld_s"}, {63'd0, out_vld_s}, 64'd1);
    if (out_vld) begin
      check({tag, "_res"},   {32'd0, res},   {32'd0, e_res});
      check({tag, "_res_s"}, {32'd0, res_s}, {32'd0, e_res_s});
      check({tag, "_ovf"},   {60'd0, ovf},   {60'd0, e_ovf});
      check({tag, "_ovf_s"}, {60'd0, ovf_s}, {60'd0, e_ovf});
    end
    tick();
  endtask

  initial begin
    int  accepts, nxt;
    bit  acc, stalled;

    rst = 1'b1; in_vld = 1'b0; n = '0; out_rdy = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_vld", {63'd0, out_vld}, 64'd0);
    check("rst_in_rdy",  {63'd0, in_rdy},  64'd1);
    mon_en = 1;
    tick();

    run_one("n3",   8'd3,   32'hF3511B09, 32'hF3511B09, 4'b0000);
    run_one("n4",   8'd4,   32'h00004010, 32'hFFFF4010, 4'b1100);
    run_one("n0",   8'd0,   32'h00000000, 32'h00000000, 4'b0000);
    run_one("n1",   8'd1,   32'h01010101, 32'h01010101, 4'b0000);
    run_one("n255", 8'hFF,  32'hFF01FF01, 32'hFFFFFFFF, 4'b1111);
    drain();

    // Stalled consumer: five operands fill the pipe, then in_rdy must drop.
    out_rdy = 1'b0; in_vld = 1'b1; n = 8'd1;
    accepts = 0; stalled = 0;
    for (int c = 0; c < 100 && accepts < 7; c++) begin
      @(negedge clk);
      acc = in_rdy;
      if (!acc && !stalled) begin
        check("bp_accepts", accepts, 64'd5);
        stalled = 1;
        repeat (3) tick();
        out_rdy = 1'b1;
      end else begin
        tick();
        if (acc) begin
          accepts++;
          n = 8'(accepts + 1);
          if (accepts == 7) in_vld = 1'b0;
        end
      end
    end
    check("bp_total", accepts, 64'd7);
    drain();

    // Streaming at full rate from an empty pipe.
    out_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_vld = 1'b1;
      n      = 8'(i);
      @(negedge clk);
      check("tp_in_rdy",  {63'd0, in_rdy},  64'd1);
      check("tp_out_vld", {63'd0, out_vld}, (i >= 5) ? 64'd1 : 64'd0);
      tick();
    end
    drain();

    // Random consumer stalls with gapped input.
    nxt = 100;
    in_vld = 1'b0;
    for (int c = 0; c < 80; c++) begin
      out_rdy = 1'($urandom_range(0, 1));
      if (!in_vld) begin
        in_vld = 1'b1;
        n      = 8'(nxt);
      end
      @(negedge clk);
      acc = in_vld && in_rdy;
      tick();
      if (acc) begin
        in_vld = 1'b0;
        nxt++;
      end
    end
    drain();

    // Reset with operands in flight discards them.
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_vld = 1'b1;
      n      = 8'(9 + i);
      tick();
    end
    in_vld = 1'b0;
    rst    = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("flush_out_vld", {63'd0, out_vld},  64'd0);
    check("flush_in_rdy",  {63'd0, in_rdy},   64'd1);
    check("flush_in_rdy_s",{63'd0, in_rdy_s}, 64'd1);
    repeat (8) tick();
    run_one("n2", 8'd2, 32'h20100804, 32'h20100804, 4'b0000);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
